// File: rtl/gpr_wb_pkg.sv
// Shared types for the GPR writeback queue: register-file geometry and the queued result entry.
package gpr_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DATA_W  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for pending writeback entries; exposes the queue contents oldest-first
// together with a valid mask so the top can build the pending scoreboard and forwarding.
module wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              push_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output wb_entry_t [DEPTH-1:0]  ages,
  output logic [DEPTH-1:0]       age_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Pointer and occupancy registers; flush wins over any concurrent push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under the occupancy mask, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Present entries in age order so position 0 is always the head.
  always_comb begin
    ages      = '0;
    age_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ages[k]      = mem_r[rd_ptr_r + PTR_W'(k)];
      age_valid[k] = (CNT_W'(k) < count_r);
    end
  end

  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/gpr_writeback_queue.sv
// Writeback queue feeding the GPR write port, with a per-register pending scoreboard.
// Optional result forwarding lookups are enabled by defining GPR_WB_FWD_EN.
module gpr_writeback_queue
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      ws,
  output logic                   we,
  output logic [DATA_W-1:0]      wData,
  output logic [NUM_REGS-1:0]    pend,
  output logic [$clog2(DEPTH):0] count
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]      fwd_rs1,
  input  logic [ADDR_W-1:0]      fwd_rs2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_dat1,
  output logic [DATA_W-1:0]      fwd_dat2
`endif
);

  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  wb_entry_t             push_entry_s;
  wb_entry_t [DEPTH-1:0] ages_s;
  logic [DEPTH-1:0]      age_valid_s;
  logic [NUM_REGS-1:0]   pend_s;
  logic                  we_r;
  logic [ADDR_W-1:0]     ws_r;
  logic [DATA_W-1:0]     wdata_r;

  assign in_ready = !full_s && !rst;
  // Writes to r0 complete the handshake but are dropped here.
  assign push_s   = in_valid && in_ready && (in_rd != '0);
  assign pop_s    = (count != '0);

  assign push_entry_s.rd   = in_rd;
  assign push_entry_s.data = in_data;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push_s),
    .pop       (pop_s),
    .push_entry(push_entry_s),
    .count     (count),
    .full      (full_s),
    .ages      (ages_s),
    .age_valid (age_valid_s)
  );

  // GPR write port: one-cycle pulse carrying the entry popped at the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      ws_r    <= '0;
      wdata_r <= '0;
    end else if (flush) begin
      we_r    <= 1'b0;
    end else if (pop_s) begin
      we_r    <= 1'b1;
      ws_r    <= ages_s[0].rd;
      wdata_r <= ages_s[0].data;
    end else begin
      we_r    <= 1'b0;
    end
  end

  assign we    = we_r;
  assign ws    = ws_r;
  assign wData = wdata_r;

  // Pending scoreboard: any queued entry or the in-flight port write marks its register.
  always_comb begin
    pend_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pend_s[ages_s[k].rd] = pend_s[ages_s[k].rd] | age_valid_s[k];
    end
    pend_s[ws_r] = pend_s[ws_r] | we_r;
    pend_s[0]    = 1'b0;
  end

  assign pend = pend_s;

`ifdef GPR_WB_FWD_EN
  // Youngest matching value wins: queue entries scanned oldest-first override the port.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0]   rs,
    input wb_entry_t [DEPTH-1:0] ages,
    input logic [DEPTH-1:0]    vld,
    input logic                port_we,
    input logic [ADDR_W-1:0]   port_ws,
    input logic [DATA_W-1:0]   port_data
  );
    logic              hit;
    logic [DATA_W-1:0] dat;
    logic              match;
    hit = port_we && (port_ws == rs);
    dat = port_data;
    for (int k = 0; k < DEPTH; k++) begin
      match = vld[k] && (ages[k].rd == rs);
      hit   = hit | match;
      dat   = match ? ages[k].data : dat;
    end
    hit = hit && (rs != '0);
    return {hit, dat};
  endfunction

  logic [DATA_W:0] fwd1_s;
  logic [DATA_W:0] fwd2_s;

  assign fwd1_s   = fwd_lookup(fwd_rs1, ages_s, age_valid_s, we_r, ws_r, wdata_r);
  assign fwd2_s   = fwd_lookup(fwd_rs2, ages_s, age_valid_s, we_r, ws_r, wdata_r);
  assign fwd_hit1 = fwd1_s[DATA_W];
  assign fwd_dat1 = fwd1_s[DATA_W-1:0];
  assign fwd_hit2 = fwd2_s[DATA_W];
  assign fwd_dat2 = fwd2_s[DATA_W-1:0];
`endif

endmodule
